// File: rtl/display_scan_ctrl.sv
// Round-robin scan of a shared 4-digit active-low 7-segment bus with frame-boundary double buffering.
// Define DISP_BLANK_EN to add an all-off anti-ghosting gap of BLANK_CYCLES at the end of every digit slot.
module display_scan_ctrl #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  en_disp,
  output logic [7:0]  digit_out,
  output logic        frame_done
);

  localparam int DIGIT_CYCLES = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
`ifdef DISP_BLANK_EN
  localparam int SHOW_CYCLES = DIGIT_CYCLES - BLANK_CYCLES;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
`else
  localparam int SHOW_CYCLES = DIGIT_CYCLES;
`endif
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

  generate
    if (DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_cfg
      $error("display_scan_ctrl: DIGIT_CYCLES must be greater than BLANK_CYCLES");
    end
  endgenerate

`ifdef DISP_BLANK_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic {IDLE, SHOW} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          fd_nxt;

  logic [15:0]   pend_val, shad_val, shad_val_nxt;
  logic [3:0]    pend_dp, shad_dp, shad_dp_nxt;
  logic          pend_flag;
  logic          copy;

  logic [3:0]    en_nxt;
  logic [7:0]    seg_nxt;
  logic [3:0]    nib;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    fd_nxt    = 1'b0;
    if (!en_in) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        SHOW: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == SHOW_LAST) begin
`ifdef DISP_BLANK_EN
            state_nxt = BLANK;
`else
            cnt_nxt = '0;
            idx_nxt = idx + 2'd1;
            fd_nxt  = (idx == 2'd3);
`endif
          end
        end
`ifdef DISP_BLANK_EN
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == SLOT_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            fd_nxt    = (idx == 2'd3);
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The shadow swap happens at the edge that ends the frame_done cycle; that same edge
  // registers the first digit-0 output, so the decode must look at the post-swap shadow.
  assign copy         = frame_done & pend_flag;
  assign shad_val_nxt = copy ? pend_val : shad_val;
  assign shad_dp_nxt  = copy ? pend_dp  : shad_dp;
  assign nib          = shad_val_nxt[{idx, 2'b00} +: 4];

  always_comb begin
    en_nxt  = 4'hF;
    seg_nxt = 8'hFF;
    if (en_in && state == SHOW) begin
      en_nxt  = ~(4'b0001 << idx);
      seg_nxt = hex_seg(nib);
      if (shad_dp_nxt[idx]) seg_nxt[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      shad_val  <= '0;
      shad_dp   <= '0;
    end else begin
      shad_val <= shad_val_nxt;
      shad_dp  <= shad_dp_nxt;
      if (load) begin
        pend_val  <= value_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (copy) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_disp    <= 4'hF;
      digit_out  <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      en_disp    <= en_nxt;
      digit_out  <= seg_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: every output cycle of each frame is compared against a spec-derived expectation.
module tb_display_scan_ctrl;

  localparam int D = 100;
`ifdef DISP_BLANK_EN
  localparam int S = D - 4;
`else
  localparam int S = D;
`endif
  localparam int FRAME = 4 * D;
  localparam logic [12:0] OFF = {4'hF, 8'hFF, 1'b0};
  localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_in = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_disp;
  logic [7:0]  digit_out;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  display_scan_ctrl #(
    .CLK_FREQ_HZ (100000),
    .REFRESH_HZ  (1000),
    .BLANK_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .load      (load),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .en_disp   (en_disp),
    .digit_out (digit_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [12:0] exp_at(input int p, input logic [15:0] v, input logic [3:0] dp);
    int d;
    int q;
    logic [3:0] en;
    logic [7:0] seg;
    logic [3:0] nib;
    d = p / D;
    q = p % D;
    en = 4'hF;
    seg = 8'hFF;
    if (q < S) begin
      en[d] = 1'b0;
      nib = v[d*4 +: 4];
      seg = SEG_TAB[nib];
      if (dp[d]) seg[7] = 1'b0;
    end
    return {en, seg, (p == FRAME - 1)};
  endfunction

  task automatic chk(input string tag, input int p, input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s p=%0d observed={en,seg,fd}=%h expected=%h", tag, p, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check n output cycles of a frame starting at its first digit-0 cycle; optionally pulse load at la and lb.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] dp, input int n,
                           input int la, input logic [15:0] lav, input logic [3:0] ladp,
                           input int lb, input logic [15:0] lbv);
    for (int p = 0; p < n; p++) begin
      chk("frame", p, {en_disp, digit_out, frame_done}, exp_at(p, v, dp));
      if (p == la) begin
        load = 1'b1; value_in = lav; dp_in = ladp;
      end else if (p == lb) begin
        load = 1'b1; value_in = lbv; dp_in = 4'b0000;
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    #2;
    rst = 1'b0;
    #1;
    chk("reset_async", 0, {en_disp, digit_out, frame_done}, OFF);
    tick();
    tick();
    chk("reset_hold", 0, {en_disp, digit_out, frame_done}, OFF);

    rst = 1'b1;
    en_in = 1'b1;
    tick();
    chk("startup_edge", 0, {en_disp, digit_out, frame_done}, OFF);
    tick();

    run_frame(16'h0000, 4'b0000, FRAME, 10, 16'h8F30, 4'b0010, -1, 16'h0);
    run_frame(16'h8F30, 4'b0010, FRAME, D + D/2, 16'h1111, 4'b0000, -1, 16'h0);
    run_frame(16'h1111, 4'b0000, FRAME, 50, 16'h2222, 4'b0000, 250, 16'h3333);
    run_frame(16'h3333, 4'b0000, FRAME, 100, 16'h5555, 4'b0000, FRAME - 1, 16'h4444);
    run_frame(16'h5555, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);
    run_frame(16'h4444, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);

    run_frame(16'h4444, 4'b0000, 150, 20, 16'h7777, 4'b0000, -1, 16'h0);
    en_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("disabled", i, {en_disp, digit_out, frame_done}, OFF);
    end
    en_in = 1'b1;
    tick();
    chk("reenable_edge", 0, {en_disp, digit_out, frame_done}, OFF);
    tick();
    run_frame(16'h4444, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);
    run_frame(16'h7777, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);

    run_frame(16'h7777, 4'b0000, 60, 30, 16'h9999, 4'b0000, -1, 16'h0);
    rst = 1'b0;
    #1;
    chk("reset_mid_slot", 0, {en_disp, digit_out, frame_done}, OFF);
    tick();
    chk("reset_mid_hold", 0, {en_disp, digit_out, frame_done}, OFF);
    rst = 1'b1;
    tick();
    chk("restart_edge", 0, {en_disp, digit_out, frame_done}, OFF);
    tick();
    run_frame(16'h0000, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);
    run_frame(16'h0000, 4'b0000, FRAME, -1, 16'h0, 4'b0000, -1, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
